fmap_tile_reader: RTL and testbench

- Read-side companion to the feature-map BRAM. It walks a rectangular tile (cols x rows, row stride) starting at a base address.
- It drives the BRAM read address and absorbs the BRAM's one-cycle read latency.
- It presents the words as a valid/ready stream with a last flag to the Conv2D datapath, e.g. a line buffer or MAC array.
- One tile per start command; backpressure never loses or duplicates a word.

---
 rtl/fmap_tile_reader.sv | 182 ++++++++++++++++++
 tb/tb_fmap_tile_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_tile_reader.sv
// fmap_tile_reader: walks a cols x rows tile of the feature-map BRAM into a valid/ready stream.
// Optional FMAP_TILE_READER_STALL_CNT_EN adds a 32-bit backpressure stall counter port.
module fmap_tile_reader #(
  parameter int AW = 16,
  parameter int BW = 8,
  parameter int LW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_adr,
  input  logic [LW-1:0] cols,
  input  logic [LW-1:0] rows,
  input  logic [AW-1:0] stride,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] radr,
  input  logic [BW-1:0] rdata,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [BW-1:0] m_data,
`ifdef FMAP_TILE_READER_STALL_CNT_EN
  output logic [31:0]   stall_cnt,
`endif
  output logic          m_last
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t        state;
  logic [AW-1:0] adr;
  logic [AW-1:0] row_base;
  logic [AW-1:0] stride_r;
  logic [AW-1:0] radr_q;
  logic [LW-1:0] cols_r;
  logic [LW-1:0] rows_r;
  logic [LW-1:0] col_cnt;
  logic [LW-1:0] row_cnt;
  logic          infl;
  logic          infl_last;
  logic [BW-1:0] fifo_d [2];
  logic [1:0]    fifo_l;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;

  logic issue;
  logic col_end;
  logic row_end;
  logic last_issue;
  logic zero_dim;
  logic fire;
  logic pop;
  logic bypass;
  logic push;

  assign issue      = (state == RUN) &&
                      ((3'(count) + 3'(infl)) < 3'd2);
  assign col_end    = col_cnt == cols_r - LW'(1);
  assign row_end    = row_cnt == rows_r - LW'(1);
  assign last_issue = issue && col_end && row_end;
  assign zero_dim   = (cols == '0) || (rows == '0);

  // The word still on rdata counts as a queue slot and can bypass an empty FIFO.
  assign m_valid = (count != 2'd0) || infl;
  assign fire    = m_valid && m_ready;
  assign pop     = fire && (count != 2'd0);
  assign bypass  = fire && (count == 2'd0);
  assign push    = infl && !bypass;

  assign m_data = (count != 2'd0) ? fifo_d[rd_ptr] :
                  infl ? rdata : '0;
  assign m_last = (count != 2'd0) ? fifo_l[rd_ptr] :
                  (infl && infl_last);

  assign radr = issue ? adr : radr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      adr      <= '0;
      row_base <= '0;
      stride_r <= '0;
      cols_r   <= '0;
      rows_r   <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (zero_dim) begin
              done <= 1'b1;
            end else begin
              state    <= RUN;
              busy     <= 1'b1;
              adr      <= base_adr;
              row_base <= base_adr;
              stride_r <= stride;
              cols_r   <= cols;
              rows_r   <= rows;
              col_cnt  <= '0;
              row_cnt  <= '0;
            end
          end
        end
        RUN: begin
          if (issue) begin
            if (col_end) begin
              col_cnt  <= '0;
              row_cnt  <= row_cnt + LW'(1);
              row_base <= row_base + stride_r;
              adr      <= row_base + stride_r;
            end else begin
              col_cnt <= col_cnt + LW'(1);
              adr     <= adr + AW'(1);
            end
            if (col_end && row_end) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fire && m_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      radr_q    <= '0;
      infl      <= 1'b0;
      infl_last <= 1'b0;
      fifo_d[0] <= '0;
      fifo_d[1] <= '0;
      fifo_l    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      radr_q    <= radr;
      infl      <= issue;
      infl_last <= last_issue;
      if (push) begin
        fifo_d[wr_ptr] <= rdata;
        fifo_l[wr_ptr] <= infl_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef FMAP_TILE_READER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (busy && m_valid && !m_ready &&
                 stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fmap_tile_reader.sv
// tb_fmap_tile_reader: random-stimulus bench for fmap_tile_reader.
// Expected words come from a tile-order address list over a BRAM model.
module tb_fmap_tile_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_adr;
  logic [9:0]  cols;
  logic [9:0]  rows;
  logic [15:0] stride;
  logic        busy;
  logic        done;
  logic [15:0] radr;
  logic [7:0]  rdata;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
`ifdef FMAP_TILE_READER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  logic [7:0] mem [0:65535];
  logic [7:0] exp_d [$];
  logic       exp_l [$];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) rdata <= mem[radr];

  fmap_tile_reader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_adr (base_adr),
    .cols     (cols),
    .rows     (rows),
    .stride   (stride),
    .busy     (busy),
    .done     (done),
    .radr     (radr),
    .rdata    (rdata),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
`ifdef FMAP_TILE_READER_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .m_last   (m_last)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] tile_adr(input logic [15:0] b,
                                           input logic [15:0] s,
                                           input int c, input int k);
    int rr;
    int kk;
    rr = k / c;
    kk = k % c;
    return b + 16'(rr * int'(s)) + 16'(kk);
  endfunction

  task automatic run_tile(input logic [15:0] b, input logic [9:0] c,
                          input logic [9:0] r, input logic [15:0] s,
                          input int mode, input bit dbl);
    int n;
    int cyc;
    int beats;
    int dones;
    int stalls;
    bit fin;
    bit hold;
    logic [7:0] held;
    bit pat [6];
    pat = '{1, 0, 0, 1, 0, 1};
    exp_d.delete();
    exp_l.delete();
    n = int'(c) * int'(r);
    for (int k = 0; k < n; k++) begin
      exp_d.push_back(mem[tile_adr(b, s, int'(c), k)]);
      exp_l.push_back(k == n - 1);
    end
    base_adr = b;
    cols     = c;
    rows     = r;
    stride   = s;
    start    = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cyc    = 1;
    beats  = 0;
    dones  = 0;
    stalls = 0;
    fin    = 0;
    hold   = 0;
    held   = '0;
    chk("busy_on", busy, 1);
    while (!fin) begin
      if (cyc > 4000) begin
        chk("timeout", 0, 1);
        break;
      end
      start = dbl && (cyc == 3);
      if (start) begin
        base_adr = 16'h4000;
        cols     = 10'd7;
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = pat[cyc % 6];
        default: m_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (mode == 0 && cyc <= n)
        chk("radr", radr, tile_adr(b, s, int'(c), cyc - 1));
      if (hold) begin
        chk("valid_hold", m_valid, 1);
        chk("data_hold", m_data, held);
      end
      if (m_valid && m_ready) begin
        if (exp_d.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          chk("data", m_data, exp_d.pop_front());
          chk("last", m_last, exp_l.pop_front());
        end
        beats++;
        if (mode == 0) chk("beat_cyc", cyc, beats + 1);
      end
      if (busy && m_valid && !m_ready) stalls++;
      hold = m_valid && !m_ready;
      held = m_data;
      if (done) begin
        dones++;
        chk("busy_off", busy, 0);
        if (mode == 0) chk("done_cyc", cyc, n + 2);
        fin = 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk("done_pulse", done, 0);
    chk("dones", dones, 1);
    chk("beats", beats, n);
    chk("left", exp_d.size(), 0);
`ifdef FMAP_TILE_READER_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stalls);
`endif
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_done", done, 0);
    end
  endtask

  initial begin
    logic [15:0] old;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst_n    = 1'b0;
    start    = 1'b0;
    base_adr = '0;
    cols     = '0;
    rows     = '0;
    stride   = '0;
    m_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_radr", radr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
`ifdef FMAP_TILE_READER_STALL_CNT_EN
    chk("rst_stall", stall_cnt, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_tile(16'h0010, 10'd3, 10'd2, 16'h0020, 0, 0);
    run_tile(16'h0010, 10'd3, 10'd2, 16'h0020, 1, 0);
    run_tile(16'hFFFE, 10'd4, 10'd1, 16'h0000, 0, 0);

    old      = radr;
    base_adr = 16'h1234;
    cols     = 10'd0;
    rows     = 10'd5;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zd_done", done, 1);
    chk("zd_busy", busy, 0);
    chk("zd_valid", m_valid, 0);
    chk("zd_radr", radr, old);
    @(posedge clk); #1;
    chk("zd_done_off", done, 0);
    chk("zd_busy2", busy, 0);
    chk("zd_radr2", radr, old);

    run_tile(16'h0200, 10'd4, 10'd3, 16'h0010, 2, 1);

    base_adr = 16'h0800;
    cols     = 10'd5;
    rows     = 10'd4;
    stride   = 16'h0040;
    start    = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_radr", radr, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_valid", m_valid, 0);
    chk("mr_data", m_data, 0);
    chk("mr_last", m_last, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_tile(16'h0800, 10'd5, 10'd4, 16'h0040, 2, 0);

    for (int t = 0; t < 6; t++) begin
      run_tile(16'($urandom), 10'($urandom_range(1, 5)),
               10'($urandom_range(1, 4)), 16'($urandom),
               (t % 2) + 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
